// File: rtl/nes_pkg.sv
// nes_pkg: shared state encoding and button layout for the NES pad poll sequencer
package nes_pkg;
    localparam int NES_BITS = 8;
    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_SEL  = 2;
    localparam int BTN_STRT = 3;
    localparam int BTN_UP   = 4;
    localparam int BTN_DN   = 5;
    localparam int BTN_L    = 6;
    localparam int BTN_R    = 7;
    typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;
endpackage

// File: rtl/nes_poll_timer.sv
// nes_poll_timer: free-running poll period counter and single-entry pending request flag
module nes_poll_timer #(
    parameter int POLL_PERIOD = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic poll_now,
    input  logic clear,
    output logic pending
);
    localparam int TW = $clog2(POLL_PERIOD);
    logic [TW-1:0] tmr;
    logic tc;
    assign tc = tmr == TW'(POLL_PERIOD - 1);
    // New requests win over clear so a request landing on the accept cycle is not lost
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tmr     <= '0;
            pending <= 1'b0;
        end else if (!en) begin
            tmr     <= '0;
            pending <= 1'b0;
        end else begin
            tmr     <= tc ? '0 : tmr + 1'b1;
            pending <= tc || poll_now || (pending && !clear);
        end
endmodule

// File: rtl/nes_poll_sequencer.sv
// nes_poll_sequencer: latches and clocks the NES pad shift register, publishing buttons and edge flags
module nes_poll_sequencer
    import nes_pkg::*;
#(
    parameter int   HALF_CYC        = 150,
    parameter int   LATCH_CYC       = 600,
    parameter int   POLL_PERIOD     = 833333,
    parameter logic DATA_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       poll_now,
    input  logic       sdata,
    output logic       srlatch,
    output logic       srclk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic       busy
);
    localparam int LW = $clog2(LATCH_CYC);
    localparam int HW = $clog2(HALF_CYC);
    localparam int CW = (LW > HW ? LW : HW) > 0 ? (LW > HW ? LW : HW) : 1;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          idx;
    logic [NES_BITS-1:0] shadow;
    logic                pending, clear, bit_in, latch_end, half_end;

    assign clear     = (state == IDLE) && pending;
    assign bit_in    = DATA_ACTIVE_LOW ? ~sdata : sdata;
    assign latch_end = cnt == CW'(LATCH_CYC - 1);
    assign half_end  = cnt == CW'(HALF_CYC - 1);

    nes_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .poll_now (poll_now),
        .clear    (clear),
        .pending  (pending)
    );

    // Pad outputs are set on the transition edge so they line up with the state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shadow   <= '0;
            srlatch  <= 1'b0;
            srclk    <= 1'b0;
            buttons  <= '0;
            valid    <= 1'b0;
            pressed  <= '0;
            released <= '0;
            busy     <= 1'b0;
        end else begin
            valid    <= 1'b0;
            pressed  <= '0;
            released <= '0;
            cnt      <= cnt + 1'b1;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                srlatch <= 1'b0;
                srclk   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (pending) begin
                            state   <= LATCH;
                            srlatch <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    LATCH: if (latch_end) begin
                        state   <= SHIFT_LO;
                        cnt     <= '0;
                        idx     <= '0;
                        srlatch <= 1'b0;
                    end
                    SHIFT_LO: if (half_end) begin
                        shadow[idx] <= bit_in;
                        cnt         <= '0;
                        state       <= idx == 3'd7 ? DONE : SHIFT_HI;
                        srclk       <= idx != 3'd7;
                    end
                    SHIFT_HI: if (half_end) begin
                        state <= SHIFT_LO;
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        srclk <= 1'b0;
                    end
                    DONE: begin
                        buttons  <= shadow;
                        pressed  <= shadow & ~buttons;
                        released <= ~shadow & buttons;
                        valid    <= 1'b1;
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
endmodule
